// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, header marker and header field layout for chan_fifo_arb
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HDR  = 2'd2,
    DATA = 2'd3
  } state_t;
  localparam logic [3:0] HDR_MARK     = 4'hA;
  localparam int         HDR_W        = 16;
  localparam int         HDR_MARK_LSB = 12;
  localparam int         HDR_CH_LSB   = 8;
  localparam int         HDR_CNT_LSB  = 0;
  function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] ch, input logic [7:0] cnt);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MARK_LSB +: 4] = HDR_MARK;
    h[HDR_CH_LSB +: 4]   = ch;
    h[HDR_CNT_LSB +: 8]  = cnt;
    return h;
  endfunction
endpackage

// File: rtl/chan_fifo_arb_rr_arb.sv
// rr_arb: round-robin priority encoder returning the first set req at or after ptr
//   req : request vector, ptr : search start index
//   gnt : granted index (ptr when nothing requests), any : some request present
module rr_arb #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt,
  output logic          any
);
  // Scan downward so the smallest offset from ptr wins; PW-bit addition wraps since N is a power of 2.
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr + PW'(k)]) begin
        gnt = ptr + PW'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/chan_fifo_arb.sv
// chan_fifo_arb: round-robin packetizer draining per-channel show-ahead FIFOs into one stream
//   clk, rst_n          : clock, asynchronous active-low reset
//   pk_sz, flush        : words per packet (0 stops grants), pulse to drain partial packets
//   ch_empty/usedw/data : per-channel FIFO status and head word; ch_rd pops the granted FIFO
//   out_data/valid/last : header word then packet words, handshaken with out_ready
//   busy, cur_ch        : packet in progress, last granted channel
module chan_fifo_arb
  import spi_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int CW  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               pk_sz,
  input  logic                     flush,
  input  logic [NCH-1:0]           ch_empty,
  input  logic [NCH*CW-1:0]        ch_usedw,
  input  logic [NCH*DW-1:0]        ch_data,
  output logic [NCH-1:0]           ch_rd,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [$clog2(NCH)-1:0]   cur_ch
);
  localparam int PW = $clog2(NCH);
  localparam int MW = CW > 8 ? CW : 8;
  state_t            state_q, state_d;
  logic [PW-1:0]     cur_ch_q, cur_ch_d, rr_ptr_q, rr_ptr_d, gnt;
  logic [7:0]        cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [NCH-1:0]    elig;
  logic [MW-1:0]     usedw [NCH];
  logic [DW-1:0]     head;
  logic              any, accept;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      usedw[i] = MW'(ch_usedw[i*CW +: CW]);
      elig[i]  = (pk_sz != 8'd0) && (flush_pend_q ? !ch_empty[i] : usedw[i] >= MW'(pk_sz));
    end
  end

  rr_arb #(.N(NCH), .PW(PW)) u_rr (
    .req (elig),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .any (any)
  );

  always_comb begin
    head = '0;
    for (int i = 0; i < NCH; i++) head = cur_ch_q == PW'(i) ? ch_data[i*DW +: DW] : head;
  end

  assign busy      = state_q != IDLE;
  assign out_valid = state_q == HDR || (state_q == DATA && !ch_empty[cur_ch_q]);
  assign out_last  = state_q == DATA && cnt_q == 8'd1;
  assign out_data  = state_q == HDR ? DW'(mk_hdr(4'(cur_ch_q), cnt_q)) : state_q == DATA ? head : '0;
  assign accept    = state_q == DATA && out_valid && out_ready;
  assign ch_rd     = accept ? NCH'(1) << cur_ch_q : '0;
  assign cur_ch    = cur_ch_q;

  always_comb begin
    state_d      = state_q;
    cur_ch_d     = cur_ch_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    // A flush pulse always wins over the empty-in-IDLE clear.
    flush_pend_d = flush | (flush_pend_q & !(state_q == IDLE && &ch_empty));
    unique case (state_q)
      IDLE: state_d = |elig ? ARB : IDLE;
      ARB: begin
        state_d  = any ? HDR : IDLE;
        cur_ch_d = any ? gnt : cur_ch_q;
        // Flush drains whatever is buffered, capped at one packet.
        cnt_d    = !any ? cnt_q :
                   (flush_pend_q && usedw[gnt] < MW'(pk_sz)) ? usedw[gnt][7:0] : pk_sz;
      end
      HDR: state_d = out_ready ? DATA : HDR;
      DATA: begin
        cnt_d    = accept ? cnt_q - 8'd1 : cnt_q;
        state_d  = accept && cnt_q == 8'd1 ? IDLE : DATA;
        rr_ptr_d = accept && cnt_q == 8'd1 ? cur_ch_q + PW'(1) : rr_ptr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_ch_q     <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end
endmodule

// File: tb/tb_chan_fifo_arb.sv
// tb_chan_fifo_arb: bench-owned channel FIFOs, packet-level reference model, directed and random traffic
module tb_chan_fifo_arb;
  localparam int NCH = 4, DW = 16, CW = 8, PW = 2, DEP = 64;
  logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0]        pk_sz = 8'd0;
  logic [NCH-1:0]    ch_empty, ch_rd;
  logic [NCH*CW-1:0] ch_usedw;
  logic [NCH*DW-1:0] ch_data;
  logic [DW-1:0]     out_data;
  logic              out_valid, out_last, busy;
  logic [PW-1:0]     cur_ch;

  chan_fifo_arb #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pk_sz(pk_sz), .flush(flush),
    .ch_empty(ch_empty), .ch_usedw(ch_usedw), .ch_data(ch_data), .ch_rd(ch_rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  logic [15:0]    mem [NCH][DEP];
  int             rp [NCH], wp [NCH], rd_cnt [NCH];
  logic [NCH-1:0] hide = '0, rd_seen = '0;
  logic           last_valid = 1'b0;
  int             n_pass = 0, n_tot = 0, last_cnt = 0;
  logic [15:0]    acc_log [$];
  // packet-level model: pending arbitration, active packet, header phase, flush pending
  bit             m_arb, m_act, m_hdr, m_fp;
  int             m_ch, m_cur, m_ptr, m_rem, m_cnt;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
  endtask

  function automatic int fsize(input int i);
    return wp[i] - rp[i];
  endfunction

  task automatic push(input int ch, input logic [15:0] v);
    mem[ch][wp[ch] % DEP] = v;
    wp[ch]++;
  endtask

  task automatic model_reset();
    m_arb = 0; m_act = 0; m_hdr = 0; m_fp = 0;
    m_ch = 0; m_cur = 0; m_ptr = 0; m_rem = 0; m_cnt = 0;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    last_cnt = 0;
    for (int i = 0; i < NCH; i++) rd_cnt[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i]            = fsize(i) == 0 || hide[i];
      ch_usedw[i*CW +: CW]   = CW'(fsize(i));
      ch_data[i*DW +: DW]    = fsize(i) > 0 ? mem[i][rp[i] % DEP] : 16'h0;
    end
  endtask

  function automatic logic [NCH-1:0] eligible();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++)
      r[i] = pk_sz != 0 && (m_fp ? !ch_empty[i] : fsize(i) >= int'(pk_sz));
    return r;
  endfunction

  // One clock: drive inputs, compare at negedge, advance model, pop FIFOs after posedge.
  task automatic cyc();
    logic [NCH-1:0] el, e_rd;
    logic [15:0]    e_dat;
    bit             e_val, e_last, nfp;
    int             g, c;
    drive();
    @(negedge clk);
    e_val = 0; e_last = 0; e_dat = 16'h0; e_rd = '0;
    if (m_act && m_hdr) begin
      e_val = 1;
      e_dat = {4'hA, 4'(m_ch), 8'(m_cnt)};
    end else if (m_act) begin
      e_val  = !ch_empty[m_ch];
      e_dat  = mem[m_ch][rp[m_ch] % DEP];
      e_last = m_rem == 1;
      e_rd   = (e_val && out_ready) ? NCH'(1) << m_ch : '0;
    end
    chk("busy", busy, m_arb || m_act);
    chk("out_valid", out_valid, e_val);
    chk("ch_rd", ch_rd, e_rd);
    chk("cur_ch", cur_ch, m_cur);
    if (e_val) begin
      chk("out_data", out_data, e_dat);
      chk("out_last", out_last, e_last);
    end
    last_valid = out_valid;
    rd_seen = ch_rd;
    if (out_valid && out_ready) begin
      acc_log.push_back(out_data);
      if (out_last) last_cnt++;
    end
    for (int i = 0; i < NCH; i++) rd_cnt[i] += int'(ch_rd[i]);
    el = eligible();
    if (!rst_n) model_reset();
    else begin
      nfp = flush || (m_fp && !(!m_act && !m_arb && &ch_empty));
      if (m_arb) begin
        m_arb = 0;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (g < 0 && el[c]) g = c;
        end
        if (g >= 0) begin
          m_act = 1; m_hdr = 1; m_ch = g; m_cur = g;
          m_cnt = (m_fp && fsize(g) < int'(pk_sz)) ? fsize(g) : int'(pk_sz);
          m_rem = m_cnt;
        end
      end else if (!m_act) m_arb = |el;
      else if (m_hdr) begin
        if (out_ready) m_hdr = 0;
      end else if (e_val && out_ready) begin
        m_rem--;
        if (m_rem == 0) begin
          m_act = 0;
          m_ptr = (m_ch + 1) % NCH;
        end
      end
      m_fp = nfp;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (rd_seen[i] && fsize(i) > 0) rp[i]++;
    flush = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0; hide = '0; pk_sz = 8'd0; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin rp[i] = 0; wp[i] = 0; end
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until(input int pkts, input int budget, input string nm);
    int n;
    n = 0;
    while (last_cnt < pkts && n < budget) begin cyc(); n++; end
    chk(nm, last_cnt, pkts);
  endtask

  task automatic run_until_words(input int words, input int budget, input string nm);
    int n;
    n = 0;
    while (acc_log.size() < words && n < budget) begin cyc(); n++; end
    chk(nm, acc_log.size(), words);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hdrs [$];
    int lows;
    for (int i = 0; i < NCH; i++) begin rp[i] = 0; wp[i] = 0; rd_cnt[i] = 0; end
    model_reset();
    drive();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_rd", ch_rd, 0);
    chk("rst_cur_ch", cur_ch, 0);
    reset_all();

    // single normal packet on ch2
    pk_sz = 8'd4; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) push(2, 16'h2000 + 16'(k));
    run_until(1, 50, "pkt1_done");
    for (int k = 0; k < 4; k++) cyc();
    chk("pkt1_words", acc_log.size(), 5);
    if (acc_log.size() == 5) begin
      chk("pkt1_hdr", acc_log[0], 16'hA204);
      chk("pkt1_w1", acc_log[1], 16'h2000);
      chk("pkt1_w4", acc_log[4], 16'h2003);
    end
    chk("pkt1_rd2", rd_cnt[2], 4);
    chk("pkt1_rd_other", rd_cnt[0] + rd_cnt[1] + rd_cnt[3], 0);

    // round robin order
    reset_all();
    pk_sz = 8'd2; out_ready = 1'b1;
    for (int i = 0; i < NCH; i++) for (int k = 0; k < 8; k++) push(i, 16'((i << 8) | k));
    run_until(5, 200, "rr_done");
    hdrs.delete();
    foreach (acc_log[j]) if (acc_log[j][15:12] == 4'hA) hdrs.push_back(acc_log[j]);
    chk("rr_hdr_count", hdrs.size(), 5);
    for (int k = 0; k < 5 && k < hdrs.size(); k++) chk("rr_order", hdrs[k][11:8], k % 4);

    // underflow for 3 cycles mid-packet
    reset_all();
    pk_sz = 8'd4; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 16'h3000 + 16'(k));
    run_until_words(3, 30, "uf_start");
    hide[0] = 1'b1;
    lows = 0;
    for (int k = 0; k < 3; k++) begin cyc(); lows += int'(!last_valid); end
    hide[0] = 1'b0;
    run_until(1, 30, "uf_done");
    chk("uf_lows", lows, 3);
    chk("uf_words", acc_log.size(), 5);

    // backpressure toggling: no duplicates, no losses
    reset_all();
    pk_sz = 8'd4;
    for (int k = 0; k < 4; k++) push(1, 16'h1100 + 16'(k));
    for (int n = 0; n < 80 && last_cnt < 1; n++) begin out_ready = n[0]; cyc(); end
    chk("bp_done", last_cnt, 1);
    chk("bp_words", acc_log.size(), 5);
    if (acc_log.size() == 5) begin
      chk("bp_hdr", acc_log[0], 16'hA104);
      for (int k = 0; k < 4; k++) chk("bp_word", acc_log[k+1], 16'h1100 + 16'(k));
    end

    // flush drains partial packets
    reset_all();
    pk_sz = 8'd8; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 16'h1500 + 16'(k));
    push(3, 16'h3500);
    cyc(); cyc();
    chk("fl_no_grant", busy, 0);
    flush = 1'b1;
    run_until(2, 60, "fl_done");
    hdrs.delete();
    foreach (acc_log[j]) if (acc_log[j][15:12] == 4'hA) hdrs.push_back(acc_log[j]);
    chk("fl_hdrs", hdrs.size(), 2);
    if (hdrs.size() == 2) begin
      chk("fl_hdr1", hdrs[0], 16'hA103);
      chk("fl_hdr2", hdrs[1], 16'hA301);
    end
    chk("fl_words", acc_log.size(), 6);
    cyc(); cyc();
    for (int k = 0; k < 3; k++) push(0, 16'h0500 + 16'(k));
    for (int k = 0; k < 6; k++) cyc();
    chk("fl_cleared_pkts", last_cnt, 2);
    chk("fl_cleared_busy", busy, 0);

    // asynchronous reset mid-DATA
    reset_all();
    pk_sz = 8'd4; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 16'h0700 + 16'(k));
    run_until(1, 40, "rs_pre");
    for (int k = 0; k < 4; k++) push(2, 16'h2700 + 16'(k));
    clear_logs();
    run_until_words(3, 40, "rs_mid");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rs_busy", busy, 0);
    chk("rs_valid", out_valid, 0);
    chk("rs_rd", ch_rd, 0);
    chk("rs_last", out_last, 0);
    chk("rs_cur", cur_ch, 0);
    chk("rs_data", out_data, 0);
    for (int k = 0; k < 4; k++) begin push(0, 16'h0800 + 16'(k)); push(1, 16'h1800 + 16'(k)); end
    cyc(); cyc();
    rst_n = 1'b1;
    clear_logs();
    run_until(1, 40, "rs_post");
    if (acc_log.size() > 0) chk("rs_first_hdr", acc_log[0], 16'hA004);
    else chk("rs_first_hdr_seen", acc_log.size(), 1);

    // randomized traffic
    reset_all();
    pk_sz = 8'd3;
    for (int n = 0; n < 3000; n++) begin
      int c;
      c = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 2) == 0 && fsize(c) < 50) push(c, 16'($urandom_range(0, 16'h7fff)));
      out_ready = $urandom_range(0, 9) < 7;
      if (n % 250 == 249) pk_sz = 8'($urandom_range(0, 6));
      flush = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 19) == 0) hide = $urandom_range(0, 3) == 0 ? NCH'($urandom_range(0, 15)) : '0;
      cyc();
    end
    chk("rand_some_pkts", last_cnt > 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
